dvp_frame_tx: RTL
=================

// Module: dvp_frame_tx
// PURPOSE
//  Camera-side transmitter for the VSYNC/HREF/8-bit-pixel frame interface consumed by the
//  harvest-detection path. Generates one complete frame per accepted start request, with
//  programmable geometry and a selectable pixel pattern of known green content.
//  Serves as the on-chip self-test source and bench stimulus for the ML receive logic.
// PARAMETERS
//  H_ACTIVE   16  active pixels per line (href=1 cycles), >=1
//  V_ACTIVE   8   active lines per frame, >=1
//  H_BLANK    4   idle cycles after each line (href=0), >=1
//  V_SYNC_LEN 3   cycles vsync is held high at frame start, >=1
//  V_BACK     2   idle cycles between vsync fall and first line, >=1
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   synchronous reset, active-low
//  start      in   1   frame request; sampled only in IDLE
//  pattern    in   2   0=solid green 0x38, 1=solid non-green 0x07, 2=checker, 3=LFSR
//  seed       in   8   LFSR seed for pattern 3 (0x00 is replaced by 0x01)
//  vsync      out  1   frame sync, high during VSYNC state
//  href       out  1   line valid, high during LINE state
//  pixel      out  8   pixel data; 0x00 whenever href=0
//  busy       out  1   high from cycle after start accept through DONE cycle
//  frame_done out  1   one-cycle pulse after last HBLANK of the frame
//  pix_count  out  16  href-cycles emitted in current/last frame
// BEHAVIOUR
//  - Reset: clk, rst_n synchronous active-low. All outputs 0, FSM=IDLE, counters 0,
//    LFSR=0x01. Takes effect on the next edge, including mid-frame. No partial frame resumes.
//  - All outputs registered. start=1 in IDLE at edge N: pattern/seed latched, pix_count<=0.
//    First vsync=1 cycle is N+1.
//  - FSM states and transitions:
//    - IDLE -> VSYNC on start.
//    - VSYNC: V_SYNC_LEN cycles, vsync=1. Then -> VBACK.
//    - VBACK: V_BACK cycles. Then -> LINE.
//    - LINE: H_ACTIVE cycles, href=1. Then -> HBLANK.
//    - HBLANK: H_BLANK cycles. Then -> LINE (y<V_ACTIVE-1) or -> DONE.
//    - DONE: 1 cycle, frame_done=1. Then -> IDLE.
//  - busy=1 in every non-IDLE state. start while busy is ignored, not queued.
//    start held high gives back-to-back frames separated by exactly one IDLE cycle.
//  - Frame length from accept: V_SYNC_LEN+V_BACK+V_ACTIVE*(H_ACTIVE+H_BLANK)+1 busy cycles.
//  - x counts 0..H_ACTIVE-1 within LINE. y counts 0..V_ACTIVE-1. Both clear at IDLE exit.
//  - Checker pattern: pixel = ((x^y)&1) ? 0x07 : 0x38.
//  - LFSR (pattern 3): 8-bit Fibonacci register, next = {l[6:0], l7^l5^l4^l3}.
//    Loaded from seed at start accept. pixel=l on each LINE cycle, advances only on LINE cycles.
//  - pix_count: +1 per LINE cycle, saturates at 0xFFFF. Holds after DONE until next start.
//  - pattern/seed changes mid-frame have no effect until the next start.
// TESTING
//  1. Defaults, pattern=0, start pulse at edge 0 -> vsync=1 cycles 1-3; first href cycle 6;
//     128 href cycles, all 0x38; frame_done only at cycle 166; busy 1-166; pix_count=128.
//  2. pattern=2 -> line0 pixels 0x38,0x07,0x38...; line1 begins 0x07; 64 pixels equal 0x38.
//  3. pattern=3, seed=0x01 -> first pixels 0x01,0x02,0x04,0x08,0x11;
//     seed=0x00 gives the identical sequence.
//  4. start pulsed during LINE -> ignored, frame timing unchanged;
//     start held high -> next vsync rises 2 cycles after frame_done.
//  5. rst_n=0 for one cycle mid-line -> next cycle vsync=href=busy=0, pixel=0x00;
//     a fresh start then yields a complete frame per test 1.
//  6. pattern=1 with the receiver attached -> pixel always 0x07; receiver reports not-ready.

Source files
------------

// File: rtl/dvp_frame_tx.sv
// VSYNC/HREF/8-bit pixel frame generator: one frame per accepted start request,
// programmable geometry and a selectable pixel pattern with known green content.
module dvp_frame_tx #(
  parameter int unsigned H_ACTIVE   = 16,
  parameter int unsigned V_ACTIVE   = 8,
  parameter int unsigned H_BLANK    = 4,
  parameter int unsigned V_SYNC_LEN = 3,
  parameter int unsigned V_BACK     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  pattern,
  input  logic [7:0]  seed,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  pixel,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] pix_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_LINE   = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [15:0] VS_LAST = 16'(V_SYNC_LEN - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BACK - 1);
  localparam logic [15:0] HA_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VA_LAST = 16'(V_ACTIVE - 1);

  localparam logic [7:0] PIX_GREEN = 8'h38;
  localparam logic [7:0] PIX_OTHER = 8'h07;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] y_q, y_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] pix_count_q, pix_count_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  pixel_q, pixel_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // cnt_q is the cycle index within the current state; in LINE it doubles as x.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    lfsr_d      = lfsr_q;
    pat_d       = pat_q;
    pix_count_d = pix_count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_VSYNC;
          cnt_d       = '0;
          y_d         = '0;
          pat_d       = pattern;
          lfsr_d      = (seed == 8'h00) ? 8'h01 : seed;
          pix_count_d = '0;
        end
      end
      S_VSYNC: begin
        if (cnt_q == VS_LAST) begin
          state_d = S_VBACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VBACK: begin
        if (cnt_q == VB_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LINE: begin
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
        if (pix_count_q != 16'hFFFF) pix_count_d = pix_count_q + 16'd1;
        if (cnt_q == HA_LAST) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          cnt_d = '0;
          if (y_q == VA_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LINE;
            y_d     = y_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the current state, so they trail it by one cycle.
  always_comb begin
    vsync_d      = (state_q == S_VSYNC);
    href_d       = (state_q == S_LINE);
    busy_d       = (state_q != S_IDLE);
    frame_done_d = (state_q == S_DONE);
    pixel_d      = 8'h00;
    if (state_q == S_LINE) begin
      case (pat_q)
        2'd0:    pixel_d = PIX_GREEN;
        2'd1:    pixel_d = PIX_OTHER;
        2'd2:    pixel_d = (cnt_q[0] ^ y_q[0]) ? PIX_OTHER : PIX_GREEN;
        default: pixel_d = lfsr_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      y_q          <= '0;
      lfsr_q       <= 8'h01;
      pat_q        <= '0;
      pix_count_q  <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      pixel_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      y_q          <= y_d;
      lfsr_q       <= lfsr_d;
      pat_q        <= pat_d;
      pix_count_q  <= pix_count_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      pixel_q      <= pixel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign vsync      = vsync_q;
  assign href       = href_q;
  assign pixel      = pixel_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;

endmodule
